// File: rtl/mmio_interconnect.sv
// mmio_interconnect: parametrised CPU-to-peripheral memory-mapped interconnect.
// Decodes each CPU request against per-slave base/mask regions (lowest index
// wins on overlap), forwards it to one slave with a valid/ready handshake and
// returns a registered one-cycle response. Unmapped addresses and slaves that
// stay silent for TIMEOUT wait cycles produce an error response.
// Optional feature: define MMIO_ERR_COUNT_EN to build the saturating error
// counter (err_count_out) and error address capture (err_addr_out).
module mmio_interconnect #(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                           TIMEOUT    = 255
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         cpu_req_in,
  input  logic [ADDR_W-1:0]            cpu_addr_in,
  input  logic [DATA_W-1:0]            cpu_data_in,
  input  logic [DATA_W/8-1:0]          cpu_we_in,
  output logic                         cpu_ready_out,
  output logic [DATA_W-1:0]            cpu_data_out,
  output logic                         cpu_err_out,
  output logic [NUM_SLAVES-1:0]        slv_req_out,
  output logic [ADDR_W-1:0]            slv_addr_out,
  output logic [DATA_W-1:0]            slv_data_out,
  output logic [DATA_W/8-1:0]          slv_we_out,
  input  logic [NUM_SLAVES-1:0]        slv_ready_in,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_data_in,
  output logic                         busy_out,
  output logic [15:0]                  err_count_out,
  output logic [ADDR_W-1:0]            err_addr_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [SEL_W-1:0]        r_sel;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_cpu_ready;
  logic [DATA_W-1:0]       r_cpu_data;
  logic                    r_cpu_err;
  logic [NUM_SLAVES-1:0]   r_slv_req;
  logic [ADDR_W-1:0]       r_slv_addr;
  logic [DATA_W-1:0]       r_slv_data;
  logic [BE_W-1:0]         r_slv_we;

  logic                    w_hit;
  logic [SEL_W-1:0]        w_dec_sel;
  logic [NUM_SLAVES-1:0]   w_dec_onehot;
  logic [ADDR_W-1:0]       w_dec_off;
  logic                    w_sel_ready;
  logic [DATA_W-1:0]       w_sel_data;
  logic                    w_timeout;

  // Address decode: scan high to low so the lowest hitting index is left standing.
  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_hit        = 1'b0;
    w_dec_sel    = '0;
    w_dec_onehot = '0;
    w_dec_off    = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr_in & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit           = 1'b1;
        w_dec_sel       = SEL_W'(i);
        w_dec_onehot    = '0;
        w_dec_onehot[i] = 1'b1;
        w_dec_off       = cpu_addr_in & ~SLAVE_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Only the selected slave's ready/data are observed; the rest are ignored.
  assign w_sel_ready = slv_ready_in[r_sel];
  assign w_sel_data  = slv_data_in[r_sel*DATA_W +: DATA_W];
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: a hit goes to WAIT, a miss straight to RESP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (cpu_req_in) w_next_state = w_hit ? ST_WAIT : ST_RESP;
      ST_WAIT: if (w_sel_ready || w_timeout) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latch, slave drive and registered CPU response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel       <= '0;
      r_cnt       <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_data  <= '0;
      r_cpu_err   <= 1'b0;
      r_slv_req   <= '0;
      r_slv_addr  <= '0;
      r_slv_data  <= '0;
      r_slv_we    <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_in) begin
            if (w_hit) begin
              r_sel      <= w_dec_sel;
              r_cnt      <= '0;
              r_slv_req  <= w_dec_onehot;
              r_slv_addr <= w_dec_off;
              r_slv_data <= cpu_data_in;
              r_slv_we   <= cpu_we_in;
            end else begin
              r_cpu_ready <= 1'b1;
              r_cpu_err   <= 1'b1;
              r_cpu_data  <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (w_sel_ready) begin
            // Ready wins over a coincident timeout; writes return zero data.
            r_slv_req   <= '0;
            r_cpu_ready <= 1'b1;
            r_cpu_err   <= 1'b0;
            r_cpu_data  <= (r_slv_we == '0) ? w_sel_data : '0;
          end else if (w_timeout) begin
            r_slv_req   <= '0;
            r_cpu_ready <= 1'b1;
            r_cpu_err   <= 1'b1;
            r_cpu_data  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready_out = r_cpu_ready;
  assign cpu_data_out  = r_cpu_data;
  assign cpu_err_out   = r_cpu_err;
  assign slv_req_out   = r_slv_req;
  assign slv_addr_out  = r_slv_addr;
  assign slv_data_out  = r_slv_data;
  assign slv_we_out    = r_slv_we;
  assign busy_out      = (r_state != ST_IDLE);

`ifdef MMIO_ERR_COUNT_EN
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_err_cnt;
  logic              w_err_evt;

  // An error response is issued on an unmapped request or a silent slave.
  assign w_err_evt = ((r_state == ST_IDLE) && cpu_req_in && !w_hit) ||
                     ((r_state == ST_WAIT) && !w_sel_ready && w_timeout);

  // Saturating error count and full CPU address of the latest erroring request.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_req_addr <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && cpu_req_in) r_req_addr <= cpu_addr_in;
      if (w_err_evt) begin
        r_err_cnt  <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
        r_err_addr <= (r_state == ST_IDLE) ? cpu_addr_in : r_req_addr;
      end
    end
  end

  assign err_count_out = r_err_cnt;
  assign err_addr_out  = r_err_addr;
`else
  assign err_count_out = '0;
  assign err_addr_out  = '0;
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed testbench for mmio_interconnect: four slaves (0 and 2 overlapping),
// TIMEOUT=8. Expected responses go into a scoreboard queue when a request is
// issued and are popped when cpu_ready_out is observed.
module tb_mmio_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  // slave3: 0x3xxx_xxxx, slave2: 0x4..0x7 (overlaps slave0), slave1: 0x2xxx_xxxx, slave0: 0x4xxx_xxxx
  localparam logic [NS*AW-1:0] BASE = {32'h3000_0000, 32'h4000_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};
`ifdef MMIO_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              cpu_req_in;
  logic [AW-1:0]     cpu_addr_in;
  logic [DW-1:0]     cpu_data_in;
  logic [DW/8-1:0]   cpu_we_in;
  logic              cpu_ready_out;
  logic [DW-1:0]     cpu_data_out;
  logic              cpu_err_out;
  logic [NS-1:0]     slv_req_out;
  logic [AW-1:0]     slv_addr_out;
  logic [DW-1:0]     slv_data_out;
  logic [DW/8-1:0]   slv_we_out;
  logic [NS-1:0]     slv_ready_in;
  logic [NS*DW-1:0]  slv_data_in;
  logic              busy_out;
  logic [15:0]       err_count_out;
  logic [AW-1:0]     err_addr_out;

  resp_t             sb[$];
  int                n_run  = 0;
  int                n_fail = 0;
  logic [15:0]       exp_cnt;
  logic [AW-1:0]     exp_eaddr;

  mmio_interconnect #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TO)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cpu_req_in    (cpu_req_in),
    .cpu_addr_in   (cpu_addr_in),
    .cpu_data_in   (cpu_data_in),
    .cpu_we_in     (cpu_we_in),
    .cpu_ready_out (cpu_ready_out),
    .cpu_data_out  (cpu_data_out),
    .cpu_err_out   (cpu_err_out),
    .slv_req_out   (slv_req_out),
    .slv_addr_out  (slv_addr_out),
    .slv_data_out  (slv_data_out),
    .slv_we_out    (slv_we_out),
    .slv_ready_in  (slv_ready_in),
    .slv_data_in   (slv_data_in),
    .busy_out      (busy_out),
    .err_count_out (err_count_out),
    .err_addr_out  (err_addr_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err_regs(input string tag);
    check({tag, " err_count"}, 32'(err_count_out), ERR_EN ? 32'(exp_cnt) : 32'h0);
    check({tag, " err_addr"}, err_addr_out, ERR_EN ? exp_eaddr : 32'h0);
  endtask

  // One transaction. slave < 0 means no slave should be selected; rdy_cyc is the
  // cycle of the slave request (1-based) in which the slave raises ready (0 = never);
  // noise is an unselected slave that holds ready high while waiting (-1 = none);
  // exp_lat counts cycles from the request-sampling edge to the response cycle.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] we, input int slave, input logic [31:0] exp_off,
                         input int rdy_cyc, input logic [31:0] rdata, input int noise,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    resp_t         r;
    logic [NS-1:0] exp_req;
    int            cyc;
    bit            done;
    exp_req = '0;
    if (slave >= 0) exp_req[slave] = 1'b1;
    for (int i = 0; i < NS; i++) slv_data_in[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
    if (slave >= 0) slv_data_in[slave*DW +: DW] = rdata;
    slv_ready_in = '0;
    @(negedge clk_in);
    cpu_req_in  = 1'b1;
    cpu_addr_in = addr;
    cpu_data_in = wdata;
    cpu_we_in   = we;
    sb.push_back('{data: exp_data, err: exp_err});
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk_in);
      cyc++;
      cpu_req_in = 1'b0;
      if (cpu_ready_out) begin
        done = 1'b1;
        r = sb.pop_front();
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " data"}, cpu_data_out, r.data);
        check({tag, " err"}, 32'(cpu_err_out), 32'(r.err));
        check({tag, " slv_req in resp"}, 32'(slv_req_out), 32'h0);
      end else begin
        check({tag, " slv_req"}, 32'(slv_req_out), 32'(exp_req));
        check({tag, " busy"}, 32'(busy_out), 32'h1);
        if (slave >= 0) begin
          check({tag, " slv_addr"}, slv_addr_out, exp_off);
          check({tag, " slv_data"}, slv_data_out, wdata);
          check({tag, " slv_we"}, 32'(slv_we_out), 32'(we));
        end
      end
      slv_ready_in = '0;
      if (!done) begin
        if (slave >= 0 && cyc == rdy_cyc) slv_ready_in[slave] = 1'b1;
        if (noise >= 0) slv_ready_in[noise] = 1'b1;
      end
    end
    slv_ready_in = '0;
    check({tag, " response seen"}, 32'(done), 32'h1);
    @(negedge clk_in);
    check({tag, " single pulse"}, 32'(cpu_ready_out), 32'h0);
    check({tag, " idle after"}, 32'(busy_out), 32'h0);
    check({tag, " data held"}, cpu_data_out, exp_data);
  endtask

  initial begin
    rst_in       = 1'b1;
    cpu_req_in   = 1'b0;
    cpu_addr_in  = '0;
    cpu_data_in  = '0;
    cpu_we_in    = '0;
    slv_ready_in = '0;
    slv_data_in  = '0;
    exp_cnt      = '0;
    exp_eaddr    = '0;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst ready", 32'(cpu_ready_out), 32'h0);
    check("rst busy", 32'(busy_out), 32'h0);
    check("rst slv_req", 32'(slv_req_out), 32'h0);
    check("rst data", cpu_data_out, 32'h0);
    check_err_regs("rst");
    rst_in = 1'b0;

    // Read from slave 1, ready in the first request cycle
    run_txn("rd_s1", 32'h2000_0010, 32'h0, 4'b0000, 1, 32'h0000_0010, 1,
            32'hCAFE_F00D, -1, 32'hCAFE_F00D, 1'b0, 2);

    // Write with byte enables, ready after five wait cycles
    run_txn("wr_s1", 32'h2000_0104, 32'h1234_5678, 4'b0011, 1, 32'h0000_0104, 6,
            32'h5555_AAAA, -1, 32'h0, 1'b0, 7);

    // Unmapped address
    run_txn("unmap", 32'hF000_0000, 32'h0, 4'b0000, -1, 32'h0, 0,
            32'h0, -1, 32'h0, 1'b1, 1);
    exp_cnt   = 16'd1;
    exp_eaddr = 32'hF000_0000;
    check_err_regs("unmap");

    // Timeout: slave 3 never answers
    run_txn("tmo", 32'h3000_0040, 32'h0, 4'b0000, 3, 32'h0000_0040, 0,
            32'h7777_7777, -1, 32'h0, 1'b1, TO + 2);
    exp_cnt   = 16'd2;
    exp_eaddr = 32'h3000_0040;
    check_err_regs("tmo");

    // Ready exactly in the timeout cycle wins
    run_txn("tmo_edge", 32'h3000_0044, 32'h0, 4'b0000, 3, 32'h0000_0044, TO + 1,
            32'h0BAD_BEEF, -1, 32'h0BAD_BEEF, 1'b0, TO + 2);
    check_err_regs("tmo_edge");

    // Overlap of slaves 0 and 2: slave 0 selected, slave 2's ready ignored
    run_txn("overlap", 32'h4000_0020, 32'h0, 4'b0000, 0, 32'h0000_0020, 3,
            32'h1111_2222, 2, 32'h1111_2222, 1'b0, 4);

    // Slave 2 alone, slave 0 raising ready as noise
    run_txn("s2_only", 32'h5000_0030, 32'h0, 4'b0000, 2, 32'h1000_0030, 2,
            32'h3333_4444, 0, 32'h3333_4444, 1'b0, 3);

    // Reset asserted mid-WAIT between clock edges
    @(negedge clk_in);
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h3000_0000;
    cpu_we_in   = 4'b0000;
    @(negedge clk_in);
    cpu_req_in = 1'b0;
    check("mid_rst pre slv_req", 32'(slv_req_out), 32'h8);
    @(negedge clk_in);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("mid_rst slv_req", 32'(slv_req_out), 32'h0);
    check("mid_rst busy", 32'(busy_out), 32'h0);
    check("mid_rst ready", 32'(cpu_ready_out), 32'h0);
    check("mid_rst data", cpu_data_out, 32'h0);
    check("mid_rst slv_addr", slv_addr_out, 32'h0);
    exp_cnt   = '0;
    exp_eaddr = '0;
    check_err_regs("mid_rst");
    repeat (2) @(negedge clk_in);
    check("mid_rst held ready", 32'(cpu_ready_out), 32'h0);
    rst_in = 1'b0;

    // Normal transaction after reset release
    run_txn("post_rst", 32'h2000_0008, 32'h0, 4'b0000, 1, 32'h0000_0008, 2,
            32'h600D_D00D, -1, 32'h600D_D00D, 1'b0, 3);
    check("sb empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
